// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the four-channel round-robin arbiter.
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  // Reset value of the last-grant pointer: channel 0 is scanned first.
  localparam logic [SEL_W-1:0] RST_LAST = 2'd3;

endpackage

// File: rtl/mux_4x1.sv
// Plain 4:1 word multiplexer driven by the arbiter's registered select.
module mux_4x1 #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] out
);

  // Route the selected input word to the output.
  always_comb begin
    case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = in3;
    endcase
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational priority rotator: first requester after 'last', wrapping mod 4.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);

  logic [SEL_W-1:0] cand;

  // Scan from farthest to nearest so the nearest requester after 'last' wins.
  always_comb begin
    idx  = '0;
    cand = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = last + SEL_W'(i);
      if (req[cand]) begin
        idx = cand;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/rr_arb_4x1.sv
// Four-channel round-robin arbiter feeding mux_4x1 over a valid/ready channel.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no word presented; waiting for any in_valid
// GRANT | word from source 'select' presented with out_valid=1 until taken
module rr_arb_4x1
  import rr_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [3:0]       in_ready,
  output logic [1:0]       select,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  input  logic             out_ready
);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  select_q, select_d;
  logic [SEL_W-1:0]  last_q, last_d;
  logic              out_valid_q, out_valid_d;

  logic              xfer;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] pick_req;
  logic [SEL_W-1:0]  pick_last;
  logic [SEL_W-1:0]  pick_idx;
  logic              pick_any;

  assign xfer      = out_valid_q & out_ready;
  assign select    = select_q;
  assign out_valid = out_valid_q;

  // The just-consumed source sits out the back-to-back re-arbitration only.
  assign mask      = in_valid & ~(NUM_CH'(1) << select_q);
  assign pick_req  = (state_q == GRANT) ? mask : in_valid;
  // On a transfer the pointer moves to the consumed source before picking.
  assign pick_last = xfer ? select_q : last_q;

  rr_pick u_pick (
    .req  (pick_req),
    .last (pick_last),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  mux_4x1 #(.WIDTH(WIDTH)) u_mux (
    .sel (select_q),
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .out (out)
  );

  // Acceptance strobe goes only to the granted source, only on a transfer.
  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[select_q] = 1'b1;
    end
  end

  // Next-state: grant on request, hold under backpressure, re-arbitrate on transfer.
  always_comb begin
    state_d     = state_q;
    select_d    = select_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          select_d    = pick_idx;
          state_d     = GRANT;
          out_valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (xfer) begin
          last_d = select_q;
          if (pick_any) begin
            select_d = pick_idx;
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      select_q    <= '0;
      last_q      <= RST_LAST;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      select_q    <= select_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_rr_arb_4x1.sv
// Self-checking bench for rr_arb_4x1: behavioural model plus directed vectors.
module tb_rr_arb_4x1;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   in_valid = 4'b0;
  logic [W-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic [3:0]   in_ready;
  logic [1:0]   select;
  logic         out_valid;
  logic [W-1:0] out;
  logic         out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arb_4x1 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in_ready  (in_ready),
    .select    (select),
    .out_valid (out_valid),
    .out       (out),
    .out_ready (out_ready)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Round-robin choice by distance: the requester closest after 'last' wins.
  function automatic int pick(input logic [3:0] req, input int last);
    int best = -1;
    int bd   = 99;
    for (int k = 0; k < 4; k++) begin
      if (req[k]) begin
        int d = (k - last - 1 + 8) % 4;
        if (d < bd) begin
          bd   = d;
          best = k;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [W-1:0] word(input int k);
    case (k)
      0:       return in0;
      1:       return in1;
      2:       return in2;
      default: return in3;
    endcase
  endfunction

  // Model: is a word being offered, from which source, and the last source served.
  bit m_busy;
  int m_sel;
  int m_last;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_sel  <= 0;
      m_last <= 3;
    end else if (!m_busy) begin
      if (in_valid != 4'b0) begin
        m_sel  <= pick(in_valid, m_last);
        m_busy <= 1'b1;
      end
    end else if (out_ready) begin
      m_last <= m_sel;
      if ((in_valid & ~(4'b0001 << m_sel)) != 4'b0) begin
        m_sel <= pick(in_valid & ~(4'b0001 << m_sel), m_sel);
      end else begin
        m_busy <= 1'b0;
      end
    end
  end

  bit         fair_on = 1'b0;
  int         wait_cnt [4];
  logic [3:0] exp_rdy;

  // Every cycle: outputs must match the model; in random phase, track starvation.
  always @(negedge clk) begin
    exp_rdy = (rst_n && m_busy && out_ready) ? (4'b0001 << m_sel) : 4'b0000;
    chk("out_valid", W'(out_valid), W'(m_busy));
    chk("select", W'(select), W'(m_sel[1:0]));
    chk("in_ready", W'(in_ready), W'(exp_rdy));
    if (m_busy) chk("out", out, word(m_sel));
    if (fair_on) begin
      for (int k = 0; k < 4; k++) begin
        if (!in_valid[k]) wait_cnt[k] = 0;
      end
      if (exp_rdy != 4'b0) begin
        for (int k = 0; k < 4; k++) begin
          if (k == m_sel) begin
            wait_cnt[k] = 0;
          end else if (in_valid[k]) begin
            wait_cnt[k]++;
            chk("starve", W'(wait_cnt[k] > 3), W'(0));
          end
        end
      end
    end
  end

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n     = 1'b0;
    in_valid  = 4'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic set_word(input int k, input logic [W-1:0] v);
    case (k)
      0:       in0 = v;
      1:       in1 = v;
      2:       in2 = v;
      default: in3 = v;
    endcase
  endtask

  logic [W-1:0] rr_exp [5];
  logic [3:0]   acc;
  int           cnt;
  int           tagc;

  initial begin
    rr_exp = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0};

    // Reset held three cycles.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_select", W'(select), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(0));

    // Round-robin across all four sources.
    @(posedge clk); #1;
    in0 = 32'hA0; in1 = 32'hA1; in2 = 32'hA2; in3 = 32'hA3;
    in_valid = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    chk("first_grant", W'(select), W'(0));
    chk("first_valid", W'(out_valid), W'(1));
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rr_out", out, rr_exp[i]);
      chk("rr_ready", W'(in_ready), W'(4'b0001 << (i % 4)));
    end

    // Backpressure on source 2.
    reset_dut();
    in2 = 32'hDEAD_BEEF;
    in_valid = 4'b0100;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("bp_select", W'(select), W'(2));
      chk("bp_out", out, 32'hDEADBEEF);
      chk("bp_in_ready", W'(in_ready), W'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", W'(in_ready), W'(4'b0100));
    @(posedge clk); #1;
    in_valid = 4'b0000;
    @(negedge clk);
    chk("bp_once", W'(in_ready), W'(0));
    chk("bp_idle", W'(out_valid), W'(0));

    // Wrap and skip: last=3, then sources 1 and 3.
    reset_dut();
    in1 = 32'hC1; in3 = 32'hC3;
    in_valid = 4'b1000;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("wrap_prime", W'(in_ready), W'(4'b1000));
    @(posedge clk); #1;
    in_valid = 4'b1010;
    @(negedge clk);
    chk("wrap_idle", W'(out_valid), W'(0));
    @(negedge clk);
    chk("wrap_g1", W'(select), W'(1));
    @(negedge clk);
    chk("wrap_g3", W'(select), W'(3));
    @(negedge clk);
    chk("wrap_g1b", W'(select), W'(1));

    // Lone streamer: one beat every two cycles.
    reset_dut();
    in0 = 32'h5555_0000;
    in_valid = 4'b0001;
    out_ready = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (in_ready[0]) cnt++;
    end
    chk("lone_count", W'(cnt), W'(4));

    // Asynchronous reset in the middle of a transfer.
    reset_dut();
    in0 = 32'hA0; in1 = 32'hA1; in2 = 32'hA2; in3 = 32'hA3;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_out_valid", W'(out_valid), W'(0));
    chk("mid_in_ready", W'(in_ready), W'(0));
    chk("mid_select", W'(select), W'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_restart", W'(select), W'(0));
    chk("mid_restart_v", W'(out_valid), W'(1));

    // Random traffic obeying hold-until-ready on each source.
    reset_dut();
    for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
    fair_on = 1'b1;
    tagc = 0;
    repeat (1000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        if (!in_valid[k] || acc[k]) begin
          in_valid[k] = 1'($urandom_range(0, 1));
          tagc++;
          set_word(k, {4'(k), 12'(tagc), 16'($urandom)});
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    fair_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb_4x1.md
# rr_arb_4x1

Four-channel round-robin arbiter sitting directly upstream of the existing 4:1 multiplexer (`mux_4x1`). It accepts valid/ready requests from four sources and registers a 2-bit `select`. It then presents the chosen source's word on a single valid/ready output channel, holding `select` stable until the word is taken. Fairness comes from a rotating last-grant pointer, so no requester is starved.

## Interface
- `WIDTH`, default 32: data width of each channel and of the output.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low. One clock domain only.
- `in_valid`  in  4  per-source request; bit k belongs to source k.
- `in0`, `in1`, `in2`, `in3`  in  WIDTH each  source data words.
- `in_ready`  out  4  per-source acceptance; one-hot or zero.
- `select`  out  2  registered grant index; drives the mux select.
- `out_valid`  out  1  the output word is valid.
- `out`  out  WIDTH  the word from the selected source (through `mux_4x1`).
- `out_ready`  in  1  the consumer accepts the word.

## Operation
- State: `state` ∈ {IDLE, GRANT}, `select[1:0]`, `last[1:0]` (last granted index).
- Reset values:
  - state = IDLE
  - select = 0
  - last = 3, so channel 0 has first priority
  - out_valid = 0
  - in_ready = 0
- Pick function: take the first k with `req[k]=1`, scanning `last+1, last+2, last+3, last+4` mod 4. The mod-4 scan wraps from 3 back to 0.
- IDLE:
  - If `in_valid != 0`, register `select = pick(in_valid)` and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - `out_valid = 1`.
  - `out = in[select]`, combinational through `mux_4x1`.
  - Transfer occurs when `out_valid && out_ready`.
  - On a transfer, `in_ready[select] = 1` in the same cycle; all other `in_ready` bits are 0.
- Without a transfer: `select` and state hold. Sources must hold `in_valid` and data stable until their `in_ready`.
- On a transfer:
  - Update `last <= select`.
  - Form `mask = in_valid & ~(1<<select)`. The consumed source is excluded for this re-arbitration only.
  - If `mask != 0`: `select <= pick(mask)` using the new `last`, and stay in GRANT (back-to-back, no bubble).
  - Otherwise go to IDLE.
- A lone source streaming continuously gets one beat every 2 cycles (GRANT, IDLE, GRANT, ...).
- `in_valid` rising during GRANT does not preempt the current grant.
- `select` never changes while `out_valid=1` and `out_ready=0`.

## Timing
- Request-to-valid latency: 1 cycle. A request sampled in IDLE at edge N gives `out_valid=1` after edge N.
- `in_ready` and `out` are combinational from registered state and inputs. `out_valid` and `select` are registers.
- Throughput: 1 word/cycle while two or more sources are requesting and `out_ready=1`.
- `rst_n` low at any time, including mid-transfer:
  - All state returns to its reset values immediately.
  - `in_ready` goes to 0.
  - No transfer is recorded in that cycle.
- Deassertion of `rst_n` takes effect at the next rising edge. The first grant can be registered on that edge.

## Structure
- Shared package `rr_arb_pkg`:
  - `state_t` enum {IDLE, GRANT}
  - constants `NUM_CH = 4`, `SEL_W = 2`
  - `RST_LAST = 2'd3`
- Sub-modules:
  - Data path instantiates the existing `mux_4x1 #(WIDTH)`, with `select` driving its select input.
  - `rr_pick` is a combinational priority rotator: inputs `req[3:0]` and `last[1:0]`, outputs `idx[1:0]` and `any`. It is instantiated once and fed by a mux of `in_valid` or `mask`.
- Estimated RTL size: ~150–200 lines.

## Test plan
- Reset:
  - Hold `rst_n=0` for 3 cycles, then release.
  - Required: `out_valid=0`, `select=0`, `in_ready=0`.
  - Then apply `in_valid=4'b1111`: first grant is `select=0`.
- Round-robin:
  - Apply `in_valid=4'b1111`, `out_ready=1`, with `in0..in3 = 32'hA0, 32'hA1, 32'hA2, 32'hA3`.
  - Required: `out` sequence A0, A1, A2, A3, A0 on consecutive cycles, with no bubbles.
- Backpressure:
  - Grant source 2 (`in2=32'hDEAD_BEEF`), then hold `out_ready=0` for 5 cycles.
  - Required: `select=2`, `out=32'hDEADBEEF`, `in_ready=0` throughout. On release, `in_ready=4'b0100` for exactly 1 cycle.
- Wrap and skip:
  - Set `last=3` via a prior grant of source 3, then apply `in_valid=4'b1010`.
  - Required: grant 1, then 3, then 1.
- Lone streamer:
  - Only `in_valid[0]=1`, with `out_ready=1` for 8 cycles.
  - Required: exactly 4 transfers, with IDLE between them.
- Reset mid-transfer:
  - Pulse `rst_n=0` asynchronously while in GRANT with `out_ready=1`.
  - Required: `out_valid` and `in_ready` drop immediately. After release, arbitration restarts from channel 0.
- Random:
  - 1000 cycles of random `in_valid`, `out_ready`, and data.
  - The bench checks that every word is delivered once, in grant order, and that no source waits more than 3 grants.
